// File: rtl/alu_result_fifo.sv
// Circular-buffer FIFO for ALU results and flags, with no bypass path.
// Optional sticky carry/overflow accumulation is enabled by defining ALU_STICKY_FLAGS_EN.
module alu_result_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    result,
  input  logic          carry,
  input  logic          zero,
  input  logic          overflow,
  input  logic [2:0]    opcode,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    out_result,
  output logic          out_carry,
  output logic          out_zero,
  output logic          out_overflow,
  output logic [2:0]    out_opcode,
  output logic [CW-1:0] count,
  input  logic          clr_sticky,
  output logic          sticky_carry,
  output logic          sticky_overflow
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [13:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;
  logic [13:0]   head;

  // Handshakes depend only on the registered count, so there is no ready/valid loop.
  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; the cleared count makes stale entries unreachable.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {opcode, overflow, zero, carry, result};
    end
  end

  always_comb begin
    head         = out_valid ? mem_q[rd_ptr_q] : '0;
    out_result   = head[7:0];
    out_carry    = head[8];
    out_zero     = head[9];
    out_overflow = head[10];
    out_opcode   = head[13:11];
  end

`ifdef ALU_STICKY_FLAGS_EN
  logic sticky_carry_q, sticky_carry_d;
  logic sticky_ovf_q, sticky_ovf_d;

  // A flagged push wins over a clear arriving in the same cycle.
  always_comb begin
    sticky_carry_d = sticky_carry_q;
    sticky_ovf_d   = sticky_ovf_q;
    if (push && carry) begin
      sticky_carry_d = 1'b1;
    end else if (clr_sticky) begin
      sticky_carry_d = 1'b0;
    end
    if (push && overflow) begin
      sticky_ovf_d = 1'b1;
    end else if (clr_sticky) begin
      sticky_ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_carry_q <= 1'b0;
      sticky_ovf_q   <= 1'b0;
    end else begin
      sticky_carry_q <= sticky_carry_d;
      sticky_ovf_q   <= sticky_ovf_d;
    end
  end

  assign sticky_carry    = sticky_carry_q;
  assign sticky_overflow = sticky_ovf_q;
`else
  logic unused_clr_sticky;
  assign unused_clr_sticky = clr_sticky;
  assign sticky_carry      = 1'b0;
  assign sticky_overflow   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
// Scoreboard bench for alu_result_fifo; sticky checks follow ALU_STICKY_FLAGS_EN.
module tb_alu_result_fifo;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready;
  logic [7:0]    result;
  logic          carry, zero, overflow;
  logic [2:0]    opcode;
  logic          out_valid, out_ready;
  logic [7:0]    out_result;
  logic          out_carry, out_zero, out_overflow;
  logic [2:0]    out_opcode;
  logic [CW-1:0] count;
  logic          clr_sticky;
  logic          sticky_carry, sticky_overflow;
  logic [13:0]   out_entry;

  int checks   = 0;
  int failures = 0;
  logic [13:0] sb_q[$];
  logic        sc_m = 1'b0;
  logic        so_m = 1'b0;

  always #5 clk = ~clk;

  alu_result_fifo #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .result(result), .carry(carry), .zero(zero), .overflow(overflow), .opcode(opcode),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_carry(out_carry), .out_zero(out_zero), .out_overflow(out_overflow),
    .out_opcode(out_opcode), .count(count), .clr_sticky(clr_sticky),
    .sticky_carry(sticky_carry), .sticky_overflow(sticky_overflow)
  );

  assign out_entry = {out_opcode, out_overflow, out_zero, out_carry, out_result};

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [13:0] mk(input logic [2:0] op, input logic ov, input logic z,
                                      input logic c, input logic [7:0] r);
    return {op, ov, z, c, r};
  endfunction

  // Entered one time unit after a rising edge; leaves at the same phase of the next cycle.
  task automatic cycle(input logic iv, input logic [13:0] ent, input logic ordy, input logic clr);
    logic do_push, do_pop;
    in_valid   = iv;
    {opcode, overflow, zero, carry, result} = ent;
    out_ready  = ordy;
    clr_sticky = clr;
    #1;
    check("out_valid", 32'(out_valid), 32'(sb_q.size() != 0));
    check("in_ready", 32'(in_ready), 32'(sb_q.size() != DEPTH));
    if (sb_q.size() != 0) check("head", 32'(out_entry), 32'(sb_q[0]));
    else                  check("idle_data", 32'(out_entry), 32'd0);
    do_push = iv && (sb_q.size() != DEPTH);
    do_pop  = ordy && (sb_q.size() != 0);
    if (do_pop) void'(sb_q.pop_front());
    if (do_push) sb_q.push_back(ent);
`ifdef ALU_STICKY_FLAGS_EN
    if (do_push && ent[8]) sc_m = 1'b1; else if (clr) sc_m = 1'b0;
    if (do_push && ent[10]) so_m = 1'b1; else if (clr) so_m = 1'b0;
`endif
    @(posedge clk);
    #1;
    check("count", 32'(count), 32'(sb_q.size()));
    check("sticky_carry", 32'(sticky_carry), 32'(sc_m));
    check("sticky_overflow", 32'(sticky_overflow), 32'(so_m));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clr_sticky = 1'b0;
    result = '0; carry = 1'b0; zero = 1'b0; overflow = 1'b0; opcode = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sticky_c", 32'(sticky_carry), 32'd0);
    rst = 1'b0;

    // Single push into empty FIFO, visible next cycle, then drained.
    cycle(1'b1, mk(3'b010, 1'b0, 1'b0, 1'b0, 8'h2D), 1'b0, 1'b0);
    check("first_head", 32'(out_result), 32'h2D);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Fill, overflow attempt, then pop while full with a push pending.
    for (int unsigned i = 1; i <= 5; i++)
      cycle(1'b1, mk(3'(i), 1'b0, 1'b0, 1'b0, 8'(i)), 1'b0, 1'b0);
    check("full_in_ready", 32'(in_ready), 32'd0);
    cycle(1'b1, mk(3'b111, 1'b1, 1'b1, 1'b1, 8'h06), 1'b1, 1'b0);
    check("full_pushpop_count", 32'(count), 32'd3);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Steady state at count 2 with simultaneous push and pop, wrapping pointers.
    for (int unsigned i = 0; i < 6; i++)
      cycle(1'b1, mk(3'(i), i[0], i[1], i[2], 8'h10 + 8'(i)), 1'b1, 1'b0);
    check("steady_count", 32'(count), 32'd2);
    repeat (3) cycle(1'b0, '0, 1'b1, 1'b0);

    // Randomised traffic with flag patterns and occasional sticky clears.
    for (int unsigned i = 0; i < 200; i++)
      cycle(1'($urandom_range(0, 1)), 14'($urandom), 1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 7) == 0));

    // Bring to count 3, then reset mid-operation.
    repeat (6) cycle(1'b0, '0, 1'b1, 1'b1);
    repeat (3) cycle(1'b1, mk(3'b001, 1'b0, 1'b0, 1'b0, 8'hA5), 1'b0, 1'b0);
    check("pre_rst_count", 32'(count), 32'd3);
    rst = 1'b1;
    #1;
    check("async_rst_count", 32'(count), 32'd0);
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    sb_q.delete();
    sc_m = 1'b0; so_m = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle(1'b1, mk(3'b000, 1'b0, 1'b0, 1'b0, 8'hFF), 1'b0, 1'b0);
    check("post_rst_head", 32'(out_entry), 32'h00FF);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Sticky flags: set, set-dominates-clear, clear alone.
    cycle(1'b1, mk(3'b011, 1'b0, 1'b0, 1'b1, 8'h80), 1'b1, 1'b0);
    cycle(1'b1, mk(3'b011, 1'b1, 1'b0, 1'b1, 8'h81), 1'b1, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
